ro_freq_meter: RTL and testbench

Multi-channel ring-oscillator frequency meter for the RO tile family. It counts rising edges of one selected, pre-divided ring-oscillator output over a fixed gate window of `clk` cycles. The result is exposed byte-wise on the dedicated output pins. It sits between the RO array and the `ui_in`/`uo_out` pin interface of the tile top and generalises the single-RO tile to `N_CH` channels with gated, saturating measurement.

---
 rtl/ro_freq_meter.sv | 116 +++++++++++
 tb/tb_ro_freq_meter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ro_freq_meter.sv
// ro_freq_meter: gated, saturating edge counter for one of N_CH ring oscillators.
// Define RO_FM_CONT_EN to enable continuous re-arming via ui_in[7].
module ro_freq_meter #(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 16,
  parameter int WIN_LOG2 = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] ro_in,
  input  logic [7:0]      ui_in,
  output logic [7:0]      uo_out
);
  typedef enum logic [1:0] {IDLE, ARM, GATE, LATCH} state_t;
  state_t state_q, state_d;
  logic [N_CH-1:0] s1_q, s2_q, s3_q, pulse_q, s1_d, s2_d, s3_d, pulse_d;
  logic [3:0] ch_q, ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, result_q, result_d;
  logic [WIN_LOG2-1:0] win_q, win_d;
  logic done_q, done_d, ovf_q, ovf_d, start_q, start_d;
  logic start, cont, pulse_sel, busy;
  logic [15:0] pulse_ext;
  logic [23:0] res_ext;
`ifdef RO_FM_CONT_EN
  assign cont = ui_in[7];
`else
  logic unused_cont;
  assign unused_cont = ui_in[7];
  assign cont = 1'b0;
`endif
  // zero-padding makes channels >= N_CH read as a constant-0 input
  assign pulse_ext = 16'(pulse_q);
  assign pulse_sel = pulse_ext[ch_q];
  assign res_ext = 24'(result_q);
  assign start = ui_in[0] & ~start_q;
  assign busy = state_q != IDLE;
  always_comb begin
    s1_d = ro_in;
    s2_d = s1_q;
    s3_d = s2_q;
    pulse_d = s2_q & ~s3_q;
    start_d = ui_in[0];
    state_d = state_q;
    ch_d = ch_q;
    cnt_d = cnt_q;
    result_d = result_q;
    win_d = win_q;
    done_d = done_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        ch_d = ui_in[4:1];
        cnt_d = '0;
        done_d = 1'b0;
        ovf_d = 1'b0;
        state_d = ARM;
      end
      ARM: begin
        win_d = '0;
        state_d = GATE;
      end
      GATE: begin
        win_d = win_q + 1'b1;
        if (pulse_sel) begin
          if (&cnt_q) ovf_d = 1'b1;
          else cnt_d = cnt_q + 1'b1;
        end
        if (&win_q) state_d = LATCH;
      end
      LATCH: begin
        result_d = cnt_q;
        done_d = 1'b1;
        state_d = cont ? ARM : IDLE;
        if (cont) begin
          cnt_d = '0;
          ch_d = ui_in[4:1];
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      pulse_q <= '0;
      start_q <= 1'b0;
      ch_q <= '0;
      cnt_q <= '0;
      result_q <= '0;
      win_q <= '0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      pulse_q <= pulse_d;
      start_q <= start_d;
      ch_q <= ch_d;
      cnt_q <= cnt_d;
      result_q <= result_d;
      win_q <= win_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
    end
  end
  always_comb
    uo_out = ui_in[6:5] == 2'd0 ? res_ext[7:0] :
             ui_in[6:5] == 2'd1 ? res_ext[15:8] :
             ui_in[6:5] == 2'd2 ? res_ext[23:16] :
             {busy, done_q, ovf_q, 1'b0, ch_q};
endmodule

// File: tb/tb_ro_freq_meter.sv
// tb_ro_freq_meter: randomized scoreboard bench; expected counts come from a sampled-edge history model.
module tb_ro_freq_meter;
  localparam int N_CH = 4, CNT_W = 8, WIN_LOG2 = 10, WIN = 1 << WIN_LOG2;
  localparam int MAXC = (1 << CNT_W) - 1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N_CH-1:0] ro_in = '0;
  logic [7:0] ui_in = '0;
  logic [7:0] uo_out;
  typedef struct {string name; logic [7:0] val;} exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;
  logic rd_v = 1'b0;
  int hp[N_CH];
  int pc[N_CH];
  int cyc = 0;
  logic [N_CH-1:0] hist [0:65535];
  ro_freq_meter #(.N_CH(N_CH), .CNT_W(CNT_W), .WIN_LOG2(WIN_LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .ui_in(ui_in), .uo_out(uo_out));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    hist[cyc+1] <= ro_in;
  end
  // each RO toggles every hp[i] clk cycles; hp[i]=0 holds it still
  always @(negedge clk)
    for (int i = 0; i < N_CH; i++)
      if (hp[i] != 0) begin
        if (pc[i] + 1 >= hp[i]) begin
          ro_in[i] = ~ro_in[i];
          pc[i] = 0;
        end else pc[i]++;
      end
  always @(negedge clk)
    if (rd_v) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty got 0x%02h", uo_out);
      end else begin
        e = exp_q.pop_front();
        if (uo_out !== e.val) begin
          errors++;
          $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, uo_out, e.val);
        end
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [1:0] sel, input logic [7:0] v, input string nm);
    ui_in[6:5] = sel;
    exp_q.push_back('{nm, v});
    rd_v = 1'b1;
    tick();
    rd_v = 1'b0;
  endtask
  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask
  task automatic start(input logic [3:0] c, output int s);
    ui_in[4:1] = c;
    ui_in[0] = 1'b1;
    tick();
    s = cyc;
    ui_in[0] = 1'b0;
  endtask
  // rising edges sampled at clk edges s-1 .. s+WIN-2 land, three cycles later, in the gate window
  function automatic int rises(input int s, input int c);
    int n = 0;
    if (c >= N_CH) return 0;
    for (int k = s - 1; k <= s + WIN - 2; k++)
      if (hist[k][c] && !hist[k-1][c]) n++;
    return n;
  endfunction
  function automatic logic [7:0] stat(input logic b, input logic d, input logic o, input logic [3:0] c);
    return {b, d, o, 1'b0, c};
  endfunction
  task automatic check_meas(input int s, input logic [3:0] c, input string tag);
    int n, r;
    wait_cyc(s + WIN + 2);
    n = rises(s, c);
    r = n > MAXC ? MAXC : n;
    rd(2'd0, 8'(r), {tag, "_b0"});
    rd(2'd1, 8'h00, {tag, "_b1"});
    rd(2'd2, 8'h00, {tag, "_b2"});
    rd(2'd3, stat(1'b0, 1'b1, n > MAXC, c), {tag, "_status"});
  endtask
  task automatic set_hp(input int a, input int b, input int c, input int d);
    hp[0] = a;
    hp[1] = b;
    hp[2] = c;
    hp[3] = d;
  endtask
  initial begin
    int s, c;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int b = 0; b < 4; b++) rd(2'(b), 8'h00, "reset_byte");
    set_hp(0, 4, 0, 0);
    repeat (10) tick();
    start(4'd1, s);
    check_meas(s, 4'd1, "window");
    start(4'd1, s);
    wait_cyc(s + 101);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rd(2'd3, 8'h00, "midgate_rst_status");
    rd(2'd0, 8'h00, "midgate_rst_b0");
    start(4'd1, s);
    check_meas(s, 4'd1, "after_rst");
    set_hp(1, 0, 0, 0);
    start(4'd0, s);
    check_meas(s, 4'd0, "saturate");
    set_hp(0, 0, 3, 0);
    start(4'd1, s);
    check_meas(s, 4'd1, "isolation");
    set_hp(1, 2, 3, 4);
    start(4'd9, s);
    check_meas(s, 4'd9, "out_of_range");
    set_hp(0, 0, 3, 0);
    start(4'd2, s);
    wait_cyc(s + 500);
    ui_in[4:1] = 4'd1;
    ui_in[0] = 1'b1;
    tick();
    ui_in[0] = 1'b0;
    wait_cyc(s + WIN + 1);
    rd(2'd3, stat(1'b1, 1'b0, 1'b0, 4'd2), "gate_start_latch_status");
    rd(2'd3, stat(1'b0, 1'b1, 1'b0, 4'd2), "gate_start_done_status");
    rd(2'd0, 8'(rises(s, 2)), "gate_start_b0");
    for (int it = 0; it < 3; it++) begin
      set_hp($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
      c = $urandom_range(0, 5);
      start(4'(c), s);
      check_meas(s, 4'(c), "random");
    end
    set_hp(0, 0, 0, 8);
    ui_in[7] = 1'b1;
    start(4'd3, s);
    wait_cyc(s + WIN + 2);
`ifdef RO_FM_CONT_EN
    rd(2'd0, 8'(rises(s, 3)), "cont_w0_b0");
    rd(2'd3, stat(1'b1, 1'b1, 1'b0, 4'd3), "cont_w0_status");
    ui_in[7] = 1'b0;
    wait_cyc(s + 2 * (WIN + 2));
    rd(2'd0, 8'(rises(s + WIN + 2, 3)), "cont_w1_b0");
    rd(2'd3, stat(1'b0, 1'b1, 1'b0, 4'd3), "cont_w1_status");
    wait_cyc(s + 3 * (WIN + 2) + 10);
    rd(2'd3, stat(1'b0, 1'b1, 1'b0, 4'd3), "cont_stopped_status");
    rd(2'd0, 8'(rises(s + WIN + 2, 3)), "cont_stopped_b0");
`else
    rd(2'd0, 8'(rises(s, 3)), "single_b0");
    rd(2'd3, stat(1'b0, 1'b1, 1'b0, 4'd3), "single_status");
    wait_cyc(s + 2 * (WIN + 2) + 10);
    rd(2'd3, stat(1'b0, 1'b1, 1'b0, 4'd3), "single_stopped_status");
    ui_in[7] = 1'b0;
`endif
    tick();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
